// File: rtl/pc_fetch_stage.sv
// PC register and IF/ID pipeline register for the fetch stage.
// Optional alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  input  logic [31:0] BranchTarget,
  input  logic        BranchTaken,
  input  logic [31:0] JumpTarget,
  input  logic        Jump,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] Instruction,
  output logic [31:0] PCResult,
  output logic [31:0] IF_ID_PCPlus4,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid,
  output logic        AlignFault
);

  logic        redirect;
  logic        pc_load;
  logic        misaligned;
  logic        flush_ifid;
  logic [31:0] sel_pc;
  logic [31:0] next_pc;

  always_comb begin
    redirect = BranchTaken | Jump;
    sel_pc   = BranchTaken ? BranchTarget : (Jump ? JumpTarget : PCAddResult);
    // a redirect must land even while the hazard unit is holding fetch
    pc_load  = redirect | ~Stall;
`ifdef PC_ALIGN_CHECK_EN
    misaligned = pc_load & (sel_pc[1:0] != 2'b00);
    next_pc    = misaligned ? EXC_VECTOR : sel_pc;
`else
    misaligned = 1'b0;
    next_pc    = sel_pc;
`endif
    flush_ifid = Flush | redirect | misaligned;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PCResult <= RESET_PC;
    end else if (pc_load) begin
      PCResult <= next_pc;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IF_ID_Instruction <= 32'h0;
      IF_ID_PCPlus4     <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else if (flush_ifid) begin
      IF_ID_Instruction <= 32'h0;
      IF_ID_PCPlus4     <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else if (pc_load) begin
      IF_ID_Instruction <= Instruction;
      IF_ID_PCPlus4     <= PCAddResult;
      IF_ID_Valid       <= 1'b1;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      AlignFault <= 1'b0;
    end else begin
      AlignFault <= misaligned;
    end
  end
`else
  logic unused_exc;
  assign unused_exc = ^EXC_VECTOR;
  assign AlignFault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage; the bench models the PC
// adder (PC+4) and an instruction memory returning ~PC.
module tb_pc_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCAddResult;
  logic [31:0] BranchTarget;
  logic        BranchTaken;
  logic [31:0] JumpTarget;
  logic        Jump;
  logic        Stall;
  logic        Flush;
  logic [31:0] Instruction;
  logic [31:0] PCResult;
  logic [31:0] IF_ID_PCPlus4;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
  logic        AlignFault;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_stage dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .PCAddResult       (PCAddResult),
    .BranchTarget      (BranchTarget),
    .BranchTaken       (BranchTaken),
    .JumpTarget        (JumpTarget),
    .Jump              (Jump),
    .Stall             (Stall),
    .Flush             (Flush),
    .Instruction       (Instruction),
    .PCResult          (PCResult),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_Valid       (IF_ID_Valid),
    .AlignFault        (AlignFault)
  );

  assign PCAddResult = PCResult + 32'd4;
  assign Instruction = ~PCResult;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // drive one cycle of control inputs after the falling edge, sample 1ns past the rising edge
  task automatic step(input logic bt, input logic [31:0] btgt, input logic j,
                      input logic [31:0] jtgt, input logic st, input logic fl);
    @(negedge Clk);
    BranchTaken  = bt;
    BranchTarget = btgt;
    Jump         = j;
    JumpTarget   = jtgt;
    Stall        = st;
    Flush        = fl;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    step(1'b0, 32'h0, 1'b1, tgt, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    BranchTaken = 1'b0; BranchTarget = 32'h0; Jump = 1'b0; JumpTarget = 32'h0;
    Stall = 1'b0; Flush = 1'b0;
    #12;
    n_checks++; if (PCResult !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PCResult, 32'h0); end
    n_checks++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", IF_ID_Valid); end
    n_checks++; if (IF_ID_Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", IF_ID_Instruction); end
    n_checks++; if (IF_ID_PCPlus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", IF_ID_PCPlus4); end
    n_checks++; if (AlignFault !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", AlignFault); end
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    n_checks++; if (PCResult !== 32'h4) begin n_fail++; $display("FAIL first_fetch_pc: got %h want %h", PCResult, 32'h4); end
    n_checks++; if (IF_ID_Valid !== 1'b1) begin n_fail++; $display("FAIL first_fetch_valid: got %b want 1", IF_ID_Valid); end
    n_checks++; if (IF_ID_PCPlus4 !== 32'h4) begin n_fail++; $display("FAIL first_fetch_pc4: got %h want %h", IF_ID_PCPlus4, 32'h4); end
    n_checks++; if (IF_ID_Instruction !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL first_fetch_instr: got %h want %h", IF_ID_Instruction, 32'hFFFF_FFFF); end
  endtask

  task automatic test_mid_reset();
    idle(); idle();
    n_checks++; if (PCResult !== 32'hC) begin n_fail++; $display("FAIL pre_reset_pc: got %h want %h", PCResult, 32'hC); end
    // assert reset asynchronously with a stall and redirect pending
    @(negedge Clk);
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h300;
    #2;
    Reset = 1'b1;
    #1;
    n_checks++; if (PCResult !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h want 0", PCResult); end
    n_checks++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", IF_ID_Valid); end
    @(posedge Clk); #1;
    n_checks++; if (PCResult !== 32'h0) begin n_fail++; $display("FAIL reset_hold_pc: got %h want 0", PCResult); end
    @(negedge Clk);
    Reset = 1'b0; Stall = 1'b0; Jump = 1'b0; JumpTarget = 32'h0;
    @(posedge Clk); #1;
    n_checks++; if (PCResult !== 32'h4) begin n_fail++; $display("FAIL post_reset_pc: got %h want %h", PCResult, 32'h4); end
    n_checks++; if (IF_ID_Valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid: got %b want 1", IF_ID_Valid); end
  endtask

  task automatic test_priority();
    jump_to(32'h10);
    n_checks++; if (PCResult !== 32'h10) begin n_fail++; $display("FAIL jump_pc: got %h want %h", PCResult, 32'h10); end
    n_checks++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL jump_valid: got %b want 0", IF_ID_Valid); end
    step(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
    n_checks++; if (PCResult !== 32'h40) begin n_fail++; $display("FAIL br_over_jump_pc: got %h want %h", PCResult, 32'h40); end
    n_checks++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL br_over_jump_valid: got %b want 0", IF_ID_Valid); end
    n_checks++; if (IF_ID_Instruction !== 32'h0) begin n_fail++; $display("FAIL br_over_jump_instr: got %h want 0", IF_ID_Instruction); end
    idle();
    n_checks++; if (PCResult !== 32'h44) begin n_fail++; $display("FAIL after_branch_pc: got %h want %h", PCResult, 32'h44); end
    n_checks++; if (IF_ID_PCPlus4 !== 32'h44) begin n_fail++; $display("FAIL after_branch_pc4: got %h want %h", IF_ID_PCPlus4, 32'h44); end
    n_checks++; if (IF_ID_Instruction !== ~32'h40) begin n_fail++; $display("FAIL after_branch_instr: got %h want %h", IF_ID_Instruction, ~32'h40); end
    // redirect during stall still lands
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (PCResult !== 32'h100) begin n_fail++; $display("FAIL br_over_stall_pc: got %h want %h", PCResult, 32'h100); end
    n_checks++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL br_over_stall_valid: got %b want 0", IF_ID_Valid); end
  endtask

  task automatic test_stall();
    jump_to(32'h1C);
    idle();
    n_checks++; if (PCResult !== 32'h20) begin n_fail++; $display("FAIL stall_setup_pc: got %h want %h", PCResult, 32'h20); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (PCResult !== 32'h20) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, PCResult, 32'h20); end
      n_checks++; if (IF_ID_PCPlus4 !== 32'h20) begin n_fail++; $display("FAIL stall_pc4[%0d]: got %h want %h", i, IF_ID_PCPlus4, 32'h20); end
      n_checks++; if (IF_ID_Instruction !== ~32'h1C) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, IF_ID_Instruction, ~32'h1C); end
      n_checks++; if (IF_ID_Valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, IF_ID_Valid); end
    end
    idle();
    n_checks++; if (PCResult !== 32'h24) begin n_fail++; $display("FAIL stall_resume_pc: got %h want %h", PCResult, 32'h24); end
    n_checks++; if (IF_ID_Instruction !== ~32'h20) begin n_fail++; $display("FAIL stall_resume_instr: got %h want %h", IF_ID_Instruction, ~32'h20); end
  endtask

  task automatic test_stall_flush();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++; if (PCResult !== 32'h24) begin n_fail++; $display("FAIL stall_flush_pc: got %h want %h", PCResult, 32'h24); end
    n_checks++; if (IF_ID_Instruction !== 32'h0) begin n_fail++; $display("FAIL stall_flush_instr: got %h want 0", IF_ID_Instruction); end
    n_checks++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL stall_flush_valid: got %b want 0", IF_ID_Valid); end
    n_checks++; if (IF_ID_PCPlus4 !== 32'h0) begin n_fail++; $display("FAIL stall_flush_pc4: got %h want 0", IF_ID_PCPlus4); end
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++; if (PCResult !== 32'h28) begin n_fail++; $display("FAIL flush_only_pc: got %h want %h", PCResult, 32'h28); end
    n_checks++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_only_valid: got %b want 0", IF_ID_Valid); end
  endtask

  task automatic test_align();
    jump_to(32'h42);
`ifdef PC_ALIGN_CHECK_EN
    n_checks++; if (PCResult !== 32'h80) begin n_fail++; $display("FAIL align_pc: got %h want %h", PCResult, 32'h80); end
    n_checks++; if (AlignFault !== 1'b1) begin n_fail++; $display("FAIL align_fault: got %b want 1", AlignFault); end
    n_checks++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL align_valid: got %b want 0", IF_ID_Valid); end
    idle();
    n_checks++; if (AlignFault !== 1'b0) begin n_fail++; $display("FAIL align_pulse_end: got %b want 0", AlignFault); end
    n_checks++; if (PCResult !== 32'h84) begin n_fail++; $display("FAIL align_next_pc: got %h want %h", PCResult, 32'h84); end
`else
    n_checks++; if (PCResult !== 32'h42) begin n_fail++; $display("FAIL noalign_pc: got %h want %h", PCResult, 32'h42); end
    n_checks++; if (AlignFault !== 1'b0) begin n_fail++; $display("FAIL noalign_fault: got %b want 0", AlignFault); end
    idle();
    n_checks++; if (PCResult !== 32'h46) begin n_fail++; $display("FAIL noalign_next_pc: got %h want %h", PCResult, 32'h46); end
    n_checks++; if (AlignFault !== 1'b0) begin n_fail++; $display("FAIL noalign_fault2: got %b want 0", AlignFault); end
`endif
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    n_checks++; if (PCResult !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup_pc: got %h want %h", PCResult, 32'hFFFF_FFFC); end
    idle();
    n_checks++; if (PCResult !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", PCResult); end
    n_checks++; if (IF_ID_PCPlus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h want 0", IF_ID_PCPlus4); end
    n_checks++; if (IF_ID_Valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b want 1", IF_ID_Valid); end
    n_checks++; if (IF_ID_Instruction !== 32'h3) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", IF_ID_Instruction, 32'h3); end
    n_checks++; if (AlignFault !== 1'b0) begin n_fail++; $display("FAIL wrap_af: got %b want 0", AlignFault); end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_priority();
    test_stall();
    test_stall_flush();
    test_align();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
